// File: rtl/param_buffer_loader_pkg.sv
// Shared constants and types for the parameter-buffer write path.
package param_buffer_loader_pkg;

    localparam int PAR_LANES     = 64;
    localparam int PAR_WORD_W    = 32;
    localparam int NUM_UNIT_TILE = 8;
    localparam int NUM_SUB_TILE  = 4;

    typedef logic [PAR_WORD_W-1:0] par_word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } ldr_state_e;

endpackage

// File: rtl/param_buffer_loader_row_assembler.sv
// Collects narrow input beats into one full buffer row; the row register
// keeps its contents across clears so the buffer sees a stable value.
module param_row_assembler
    import param_buffer_loader_pkg::*;
#(
    parameter int LANES      = PAR_LANES,
    parameter int BEAT_LANES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      accept,
    input  logic      clear,
    input  par_word_t beat [BEAT_LANES],
    output par_word_t row  [LANES],
    output logic      row_full
);

    localparam int BEATS = LANES / BEAT_LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0] beat_cnt;

    assign row_full = accept && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    // Constant lane indices keep the write decode a plain mux per lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                row[i] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < BEATS; k++) begin
                for (int j = 0; j < BEAT_LANES; j++) begin
                    if (beat_cnt == CW'(k)) begin
                        row[k*BEAT_LANES + j] <= beat[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/param_buffer_loader.sv
// Parameter buffer writer: assembles beats into rows and walks the tile
// in PE-array order (unit index inner, sub index outer).
module param_buffer_loader
    import param_buffer_loader_pkg::*;
#(
    parameter int LANES      = PAR_LANES,
    parameter int BEAT_LANES = 4,
    parameter int NUM_UNIT   = NUM_UNIT_TILE,
    parameter int NUM_SUB    = NUM_SUB_TILE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  par_word_t                  in_data [BEAT_LANES],
    input  logic                       in_valid,
    output logic                       in_ready,
    output par_word_t                  par_out [LANES],
    output logic                       par_write_en,
    output logic [$clog2(NUM_SUB)-1:0] sub_tile_idx,
    output logic [$clog2(NUM_UNIT)-1:0] unit_tile_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int UW = $clog2(NUM_UNIT);
    localparam int SW = $clog2(NUM_SUB);
    localparam logic [UW-1:0] UNIT_LAST = UW'(NUM_UNIT - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(NUM_SUB - 1);

    ldr_state_e state, state_next;
    logic       accept;
    logic       clear;
    logic       row_full;
    logic       last_row;

    assign accept   = in_valid && in_ready;
    assign last_row = (sub_tile_idx == SUB_LAST) && (unit_tile_idx == UNIT_LAST);

    param_row_assembler #(
        .LANES      (LANES),
        .BEAT_LANES (BEAT_LANES)
    ) u_row (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .clear    (clear),
        .beat     (in_data),
        .row      (par_out),
        .row_full (row_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        par_write_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        clear        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    clear      = 1'b1;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (row_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                par_write_en = 1'b1;
                busy         = 1'b1;
                clear        = 1'b1;
                state_next   = last_row ? DONE : FILL;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Indices advance when leaving WRITE so they stay put during the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_tile_idx  <= '0;
            unit_tile_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sub_tile_idx  <= '0;
                        unit_tile_idx <= '0;
                    end
                end
                WRITE: begin
                    if (unit_tile_idx == UNIT_LAST) begin
                        unit_tile_idx <= '0;
                        sub_tile_idx  <= (sub_tile_idx == SUB_LAST) ? '0 : sub_tile_idx + 1'b1;
                    end else begin
                        unit_tile_idx <= unit_tile_idx + 1'b1;
                    end
                end
                DONE: begin
                    sub_tile_idx  <= '0;
                    unit_tile_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_buffer_loader.sv
// Self-checking bench for param_buffer_loader: a table of whole-tile runs
// checked cycle by cycle against a beat-queue model, plus idle/reset sequences.
module tb_param_buffer_loader;
    import param_buffer_loader_pkg::*;

    localparam int ROWS  = 32;
    localparam int BEATS = 16;
    localparam int TOTAL_BEATS = ROWS * BEATS;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    par_word_t  in_data [4];
    logic       in_valid;
    logic       in_ready;
    par_word_t  par_out [64];
    logic       par_write_en;
    logic [1:0] sub_tile_idx;
    logic [2:0] unit_tile_idx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    param_buffer_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .par_out       (par_out),
        .par_write_en  (par_write_en),
        .sub_tile_idx  (sub_tile_idx),
        .unit_tile_idx (unit_tile_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // mode: 0 valid always high, 1 valid toggles 1,0,1,0, 2 random valid
    typedef struct {
        int mode;
        bit rnd;
        int base;
        int restart_row;
        bit start_in_done;
        int abort_beats;
        int exp_writes;
        int exp_dones;
        int exp_cycles;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        int nz = 0;
        for (int i = 0; i < 64; i++) if (par_out[i] !== 32'h0) nz++;
        check({tag, "/par_out_zero"}, nz, 0);
        check({tag, "/in_ready"}, in_ready, 0);
        check({tag, "/wr_en"}, par_write_en, 0);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/done"}, done, 0);
        check({tag, "/sub"}, sub_tile_idx, 0);
        check({tag, "/unit"}, unit_tile_idx, 0);
    endtask

    task automatic run_tile(input vec_t v, input string tag);
        par_word_t words[$];
        par_word_t pend [4];
        int  nbeats = 0, writes = 0, dones = 0, tile_cycles = 0, nbad;
        bit  pend_write = 0, last_wr_prev = 0, fill, exp_done_now, accepted;
        bit  restart_fired = 0, finished = 0, aborted = 0;

        for (int j = 0; j < 4; j++) pend[j] = v.rnd ? par_word_t'($urandom) : par_word_t'(v.base + j);
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            exp_done_now = last_wr_prev;
            fill = !pend_write && !exp_done_now && (nbeats < TOTAL_BEATS);
            check({tag, "/in_ready"}, in_ready, fill);
            check({tag, "/wr_en"}, par_write_en, pend_write);
            check({tag, "/busy"}, busy, !exp_done_now);
            check({tag, "/done"}, done, exp_done_now);
            if (par_write_en) begin
                nbad = 0;
                for (int i = 0; i < 64; i++) begin
                    if (writes*64 + i >= words.size()) nbad++;
                    else if (par_out[i] !== words[writes*64 + i]) nbad++;
                end
                check({tag, "/row_data_bad_lanes"}, nbad, 0);
                check({tag, "/sub_idx"}, sub_tile_idx, writes / 8);
                check({tag, "/unit_idx"}, unit_tile_idx, writes % 8);
                writes++;
            end
            if (done) begin
                dones++;
                tile_cycles = cyc + 1;
            end
            if (exp_done_now) begin
                finished = 1;
                in_valid = 1'b0;
                start = v.start_in_done;
            end else begin
                case (v.mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 0);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                for (int j = 0; j < 4; j++) in_data[j] = pend[j];
                start = 1'b0;
                if (v.restart_row >= 0 && !restart_fired && writes == v.restart_row && fill) begin
                    start = 1'b1;
                    restart_fired = 1;
                end
                accepted = in_valid && fill;
                last_wr_prev = pend_write && (nbeats == TOTAL_BEATS);
                if (accepted) begin
                    for (int j = 0; j < 4; j++) words.push_back(pend[j]);
                    nbeats++;
                    for (int j = 0; j < 4; j++)
                        pend[j] = v.rnd ? par_word_t'($urandom) : par_word_t'(v.base + nbeats*4 + j);
                end
                pend_write = accepted && (nbeats % BEATS == 0);
                if (accepted && v.abort_beats > 0 && nbeats == v.abort_beats) begin
                    @(negedge clk);
                    rst = 1'b1;
                    #1;
                    check_all_zero({tag, "/mid_reset"});
                    in_valid = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    aborted = 1;
                    finished = 1;
                end
            end
            if (!aborted) @(negedge clk);
        end
        if (!finished) check({tag, "/timeout"}, 0, 1);
        check({tag, "/writes"}, writes, v.exp_writes);
        check({tag, "/dones"}, dones, v.exp_dones);
        if (v.exp_cycles > 0) check({tag, "/tile_cycles"}, tile_cycles, v.exp_cycles);
        start = 1'b0;
        if (!aborted) begin
            for (int c = 0; c < 5; c++) begin
                check({tag, "/post_busy"}, busy, 0);
                check({tag, "/post_ready"}, in_ready, 0);
                check({tag, "/post_wr"}, par_write_en, 0);
                check({tag, "/post_done"}, done, 0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mode: 0, rnd: 0, base: 0,        restart_row: -1, start_in_done: 0, abort_beats: 0,  exp_writes: 32, exp_dones: 1, exp_cycles: 545};
        tbl[1] = '{mode: 1, rnd: 0, base: 'h10000,  restart_row: -1, start_in_done: 0, abort_beats: 0,  exp_writes: 32, exp_dones: 1, exp_cycles: 0};
        tbl[2] = '{mode: 0, rnd: 1, base: 0,        restart_row: 5,  start_in_done: 0, abort_beats: 0,  exp_writes: 32, exp_dones: 1, exp_cycles: 545};
        tbl[3] = '{mode: 0, rnd: 0, base: 'h20000,  restart_row: -1, start_in_done: 0, abort_beats: 56, exp_writes: 3,  exp_dones: 0, exp_cycles: 0};
        tbl[4] = '{mode: 0, rnd: 1, base: 0,        restart_row: -1, start_in_done: 0, abort_beats: 0,  exp_writes: 32, exp_dones: 1, exp_cycles: 545};
        tbl[5] = '{mode: 2, rnd: 1, base: 0,        restart_row: -1, start_in_done: 1, abort_beats: 0,  exp_writes: 32, exp_dones: 1, exp_cycles: 0};

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) in_data[j] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Valid held high while idle must never be taken.
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) in_data[j] = 32'hdead_0000 + j;
        for (int c = 0; c < 20; c++) begin
            check("idle/in_ready", in_ready, 0);
            check("idle/wr_en", par_write_en, 0);
            check("idle/busy", busy, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_tile(tbl[t], $sformatf("tile%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_buffer_loader.md
Name: param_buffer_loader

Overview:
- Writer side of the 64-lane parameter buffer. It accepts a narrow valid/ready stream of 32-bit parameter words from the DMA/feeder.
- Beats are assembled into full 64-lane rows. Each completed row is written into the buffer with a one-cycle write strobe plus sub-tile and unit-tile indices.
- Indices walk the whole tile in PE-array order: unit-tile index is inner, sub-tile index is outer.
- Sits between the off-chip parameter fetch path and the parameter buffer's write port.

Parameters:
- LANES, 64, 32-bit lanes per buffer row; must equal the buffer width.
- BEAT_LANES, 4, 32-bit words per input beat; must divide LANES.
- NUM_UNIT, 8, unit tiles per sub tile; unit index width is 3.
- NUM_SUB, 4, sub tiles per tile; sub index width is 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins loading one full tile; ignored unless idle.
- in_data  in  BEAT_LANES x 32  input beat; element j is lane j of the beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader accepts a beat this cycle.
- par_out  out  LANES x 32  assembled row presented to the buffer write data.
- par_write_en  out  1  one-cycle write strobe to the buffer.
- sub_tile_idx  out  2  sub-tile index of the row being written.
- unit_tile_idx  out  3  unit-tile index of the row being written.
- busy  out  1  high from the cycle after an accepted start until the cycle done rises.
- done  out  1  one-cycle pulse after the last row write.

Behaviour:
- Reset values: in_ready=0, par_out all 0, par_write_en=0, sub_tile_idx=0, unit_tile_idx=0, busy=0, done=0, state=IDLE, beat counter=0.
- Rows per tile: R = NUM_UNIT*NUM_SUB = 32. Beats per row: B = LANES/BEAT_LANES = 16.
- IDLE:
  - in_ready=0.
  - start=1 moves to FILL, clears the beat counter and both indices, and sets busy next cycle.
- FILL:
  - in_ready=1 combinationally from the state only; it never depends on in_valid.
  - A beat is accepted when in_valid && in_ready.
  - Beat k (0..B-1) is written to par_out[k*BEAT_LANES + j] = in_data[j] on the accepting edge, then the beat counter increments.
  - No acceptance means no state change; gaps in in_valid are allowed.
  - Accepting beat B-1 moves to WRITE.
- WRITE (exactly one cycle):
  - par_write_en=1, with par_out holding the complete row and indices holding the row's position.
  - in_ready=0.
  - On exit: the beat counter clears. unit_tile_idx increments. If it was NUM_UNIT-1, it wraps to 0 and sub_tile_idx increments.
  - If the row just written is the last one (sub=NUM_SUB-1, unit=NUM_UNIT-1), go to DONE; otherwise go to FILL.
- DONE (one cycle):
  - done=1, busy=0, indices reset to 0.
  - Next state is IDLE. A start in this cycle is ignored.
- Latency: the first write strobe occurs exactly one cycle after the 16th beat is accepted. With in_valid held high, a full tile takes R*(B+1)+1 = 545 cycles from the first FILL cycle to done.
- par_out holds its last value between writes; the buffer samples it only on par_write_en.
- start while busy is ignored; it neither restarts the tile nor changes the indices.
- in_valid while not in FILL: the beat is not accepted, so the producer must hold it.
- Reset asserted mid-tile returns every output to its reset value immediately. The partial row and partial tile are discarded, with no write and no done.
- Index outputs are registered and stable for the whole WRITE cycle.

Decomposition:
- Shared accelerator package holds:
  - constants PAR_LANES=64, PAR_WORD_W=32, NUM_UNIT_TILE=8, NUM_SUB_TILE=4;
  - typedef par_word_t (logic[31:0]);
  - typedef ldr_state_e {IDLE, FILL, WRITE, DONE}.
- One natural sub-module, param_row_assembler: beat counter plus lane register array, with inputs accept and clear and output row_full.
- The FSM and index counters stay in the top module.

Test Plan:
- Reset then a single start, feeding beat k with lanes {4k, 4k+1, 4k+2, 4k+3} for rows 0..31 with in_valid held high. Require:
  - 32 write strobes;
  - first strobe with par_out[i]=i, sub=0, unit=0;
  - strobe 8 with sub=1, unit=0;
  - strobe 31 with sub=3, unit=7;
  - done exactly one cycle after strobe 31, and 545 cycles in total.
- in_valid toggling 1,0,1,0 during row 0. Require no beat lost or duplicated, the row equal to the sent data, and in_ready low during the WRITE cycle.
- start pulsed again at row 5. Require the index sequence to be unaffected, still 32 writes, and one done.
- rst asserted after beat 7 of row 3. Require par_write_en=0, busy=0, indices 0 and par_out 0 immediately. After a new start, the first write carries sub=0, unit=0 and only the new data.
- in_valid=1 while in IDLE with no start. Require in_ready=0, no writes, busy=0 for 20 cycles.
- start asserted during the DONE cycle. Require it to be ignored, with the block returning to IDLE with busy=0.
